// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Shift-kind encodings, direction constants and the shift-amount width rule.
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_LOGICAL = 2'b00,
    SHIFT_ARITH   = 2'b01,
    SHIFT_ROTATE  = 2'b10
  } shift_mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic int shamt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One registered shift stage: shifts by 2**STAGE_IDX when its amount bit is set.
// Optional sticky accumulation is enabled by BARREL_SHIFTER_STICKY_EN.
module barrel_shift_stage
  import shifter_pkg::*;
#(
  parameter int  WIDTH     = 32,
  parameter int  TAG_W     = 4,
  parameter int  STAGE_IDX = 0,
  localparam int SH_W      = shamt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SH_W-1:0]  in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_dir,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_ovf,
`ifdef BARREL_SHIFTER_STICKY_EN
  input  logic             in_sticky,
  output logic             out_sticky,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SH_W-1:0]  out_amt,
  output logic [1:0]       out_mode,
  output logic             out_dir,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  localparam int SHIFT = 1 << STAGE_IDX;

  logic               r_valid;
  logic [WIDTH-1:0]   r_data;
  logic [SH_W-1:0]    r_amt;
  logic [1:0]         r_mode;
  logic               r_dir;
  logic [TAG_W-1:0]   r_tag;
  logic               r_ovf;

  logic [2*WIDTH-1:0] w_dd;
  logic [2*WIDTH-1:0] w_dd_l;
  logic [2*WIDTH-1:0] w_dd_r;
  logic [WIDTH-1:0]   w_shl;
  logic [WIDTH-1:0]   w_lsr;
  logic [WIDTH-1:0]   w_asr;
  logic [WIDTH-1:0]   w_top;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_take;
  logic               w_top_mixed;
  logic               w_ovf_here;

  // Rotates come from the doubled operand so no part-select depends on STAGE_IDX.
  assign w_dd        = {in_data, in_data};
  assign w_dd_l      = w_dd << SHIFT;
  assign w_dd_r      = w_dd >> SHIFT;
  assign w_shl       = in_data << SHIFT;
  assign w_lsr       = in_data >> SHIFT;
  assign w_asr       = $signed(in_data) >>> SHIFT;
  // Top SHIFT+1 bits equal <=> this sign-extended slice is all zeros or all ones.
  assign w_top       = $signed(in_data) >>> (WIDTH - 1 - SHIFT);
  assign w_top_mixed = (w_top != '0) && (w_top != '1);
  assign w_take      = in_amt[STAGE_IDX];

  always_comb begin
    w_shifted  = in_data;
    w_ovf_here = 1'b0;
    if (w_take) begin
      if (in_dir == DIR_LEFT) begin
        w_shifted  = (in_mode == SHIFT_ROTATE) ? w_dd_l[2*WIDTH-1:WIDTH] : w_shl;
        w_ovf_here = (in_mode == SHIFT_ARITH) && w_top_mixed;
      end else begin
        case (in_mode)
          SHIFT_ROTATE: w_shifted = w_dd_r[WIDTH-1:0];
          SHIFT_ARITH:  w_shifted = w_asr;
          default:      w_shifted = w_lsr;
        endcase
      end
    end
  end

  // Handshake: a beat moves when valid & ready. This stage accepts whenever it is
  // empty or its current beat leaves in the same cycle, so bubbles collapse.
  assign in_ready = !r_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
      r_mode  <= '0;
      r_dir   <= 1'b0;
      r_tag   <= '0;
      r_ovf   <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= w_shifted;
        r_amt  <= in_amt;
        r_mode <= in_mode;
        r_dir  <= in_dir;
        r_tag  <= in_tag;
        r_ovf  <= in_ovf || w_ovf_here;
      end
    end
  end

`ifdef BARREL_SHIFTER_STICKY_EN
  logic [WIDTH-1:0] w_low_bits;
  logic             w_sticky_here;
  logic             r_sticky;

  assign w_low_bits    = in_data << (WIDTH - SHIFT);
  assign w_sticky_here = w_take && (in_dir == DIR_RIGHT) &&
                         (in_mode != SHIFT_ROTATE) && (w_low_bits != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (in_ready && in_valid) begin
      r_sticky <= in_sticky || w_sticky_here;
    end
  end

  assign out_sticky = r_sticky;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_amt   = r_amt;
  assign out_mode  = r_mode;
  assign out_dir   = r_dir;
  assign out_tag   = r_tag;
  assign out_ovf   = r_ovf;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter: one register stage per shift-amount bit.
// Define BARREL_SHIFTER_STICKY_EN to add the out_sticky right-shift lost-bit flag.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  TAG_W = 4,
  localparam int SH_W  = shamt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SH_W-1:0]  in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_dir,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
`ifdef BARREL_SHIFTER_STICKY_EN
  output logic             out_sticky,
`endif
  output logic [TAG_W-1:0] out_tag
);

  // Index k is the input of stage k; index SH_W is the pipe output.
  logic             w_valid [SH_W+1];
  logic             w_ready [SH_W+1];
  logic [WIDTH-1:0] w_data  [SH_W+1];
  logic [SH_W-1:0]  w_amt   [SH_W+1];
  logic [1:0]       w_mode  [SH_W+1];
  logic             w_dir   [SH_W+1];
  logic [TAG_W-1:0] w_tag   [SH_W+1];
  logic             w_ovf   [SH_W+1];
`ifdef BARREL_SHIFTER_STICKY_EN
  logic             w_sticky [SH_W+1];

  assign w_sticky[0] = 1'b0;
  assign out_sticky  = w_sticky[SH_W];
`endif

  assign w_valid[0]    = in_valid;
  assign w_data[0]     = in_data;
  assign w_amt[0]      = in_amt;
  assign w_mode[0]     = in_mode;
  assign w_dir[0]      = in_dir;
  assign w_tag[0]      = in_tag;
  assign w_ovf[0]      = 1'b0;
  assign w_ready[SH_W] = out_ready;

  // Held low during reset so upstream never sees a transfer that reset discards.
  assign in_ready = rst_n && w_ready[0];

  for (genvar k = 0; k < SH_W; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH     (WIDTH),
      .TAG_W     (TAG_W),
      .STAGE_IDX (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (w_valid[k]),
      .in_ready   (w_ready[k]),
      .in_data    (w_data[k]),
      .in_amt     (w_amt[k]),
      .in_mode    (w_mode[k]),
      .in_dir     (w_dir[k]),
      .in_tag     (w_tag[k]),
      .in_ovf     (w_ovf[k]),
`ifdef BARREL_SHIFTER_STICKY_EN
      .in_sticky  (w_sticky[k]),
      .out_sticky (w_sticky[k+1]),
`endif
      .out_valid  (w_valid[k+1]),
      .out_ready  (w_ready[k+1]),
      .out_data   (w_data[k+1]),
      .out_amt    (w_amt[k+1]),
      .out_mode   (w_mode[k+1]),
      .out_dir    (w_dir[k+1]),
      .out_tag    (w_tag[k+1]),
      .out_ovf    (w_ovf[k+1])
    );
  end

  assign out_valid = w_valid[SH_W];
  assign out_data  = w_data[SH_W];
  assign out_tag   = w_tag[SH_W];
  assign out_ovf   = w_ovf[SH_W];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter at WIDTH=8, TAG_W=4.
// Covers out_sticky when BARREL_SHIFTER_STICKY_EN is defined.
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int SW = 3;
  localparam int EW = W + TW + 2;  // {sticky, tag, ovf, data}

`ifdef BARREL_SHIFTER_STICKY_EN
  localparam logic [EW-1:0] CMP_MASK = {EW{1'b1}};
`else
  localparam logic [EW-1:0] CMP_MASK = {1'b0, {(EW-1){1'b1}}};
`endif
  localparam logic [EW-1:0] DIR_MASK = {1'b0, {(EW-1){1'b1}}};

  localparam logic [W-1:0]  T_D [12] = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h30, 8'h30,
                                         8'hF0, 8'h96, 8'h96, 8'h81, 8'h40, 8'h80};
  localparam logic [SW-1:0] T_A [12] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd1, 3'd2,
                                         3'd3, 3'd0, 3'd7, 3'd7, 3'd1, 3'd7};
  localparam logic [1:0]    T_M [12] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01,
                                         2'b01, 2'b01, 2'b11, 2'b10, 2'b01, 2'b01};
  localparam logic          T_R [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [W-1:0]  T_E [12] = '{8'hF2, 8'hB4, 8'hD2, 8'h12, 8'h60, 8'hC0,
                                         8'h80, 8'h96, 8'h00, 8'h03, 8'h80, 8'hFF};
  localparam logic          T_O [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_amt = '0;
  logic [1:0]    in_mode = '0;
  logic          in_dir = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic [TW-1:0] out_tag;
`ifdef BARREL_SHIFTER_STICKY_EN
  logic          out_sticky;
`endif

  int            n_cmp = 0;
  int            n_err = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_mode    (in_mode),
    .in_dir     (in_dir),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
`ifdef BARREL_SHIFTER_STICKY_EN
    .out_sticky (out_sticky),
`endif
    .out_tag    (out_tag)
  );

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [W-1:0] d, input int amt,
                                          input logic [1:0] mode, input logic dir,
                                          input logic [TW-1:0] tag);
    logic [W-1:0] r;
    logic         ovf;
    logic         st;
    int           v;
    int           src;
    r   = '0;
    ovf = 1'b0;
    st  = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (dir == DIR_LEFT) begin
        src = i - amt;
        if (src >= 0) r[i] = d[src];
        else if (mode == SHIFT_ROTATE) r[i] = d[src + W];
      end else begin
        src = i + amt;
        if (src < W) r[i] = d[src];
        else if (mode == SHIFT_ROTATE) r[i] = d[src - W];
        else if (mode == SHIFT_ARITH) r[i] = d[W-1];
      end
    end
    if (mode == SHIFT_ARITH && dir == DIR_LEFT) begin
      v   = int'($signed(d)) * (1 << amt);
      ovf = (v > (2 ** (W - 1)) - 1) || (v < -(2 ** (W - 1)));
    end
    if (dir == DIR_RIGHT && mode != SHIFT_ROTATE)
      for (int i = 0; i < amt; i++) st = st | d[i];
    return {st, tag, ovf, r};
  endfunction

  function automatic logic [EW-1:0] act_vec();
`ifdef BARREL_SHIFTER_STICKY_EN
    return {out_sticky, out_tag, out_ovf, out_data};
`else
    return {1'b0, out_tag, out_ovf, out_data};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [W-1:0] d, input logic [SW-1:0] a,
                            input logic [1:0] m, input logic dir, input logic [TW-1:0] t);
    in_data = d;
    in_amt  = a;
    in_mode = m;
    in_dir  = dir;
    in_tag  = t;
  endtask

  task automatic drive_random(input logic [TW-1:0] t);
    drive_beat(W'($urandom_range(0, 255)), SW'($urandom_range(0, W - 1)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), t);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_data !== '0 || out_ovf !== 1'b0 || out_tag !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h ovf=%b tag=%h want 0/0/0", out_data, out_ovf, out_tag);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready_release: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [EW-1:0] exp;
    int            lat;
    for (int i = 0; i < 12; i++) begin
      drive_beat(T_D[i], T_A[i], T_M[i], T_R[i], TW'(i));
      in_valid  = 1'b1;
      out_ready = 1'b1;
      exp_q.push_back({1'b0, TW'(i), T_O[i], T_E[i]});
      @(negedge clk);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (lat < 20) begin
        @(negedge clk);
        if (out_valid) break;
        @(posedge clk);
        #1 lat++;
      end
      exp = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || lat != SW) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d cycles (valid=%b) want %0d", i, lat, out_valid, SW);
      end
      n_cmp++;
      if ((act_vec() & DIR_MASK) !== (exp & DIR_MASK)) begin
        n_err++;
        $display("FAIL directed_result[%0d]: got data=%h ovf=%b tag=%h want data=%h ovf=%b tag=%h",
                 i, out_data, out_ovf, out_tag, exp[W-1:0], exp[W], exp[W+TW:W+1]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // rnd=0: out_ready follows 1,0,0,1 repeating; rnd=1: random out_ready.
  task automatic test_back_to_back(input int n_beats, input bit rnd);
    int            sent;
    int            got;
    int            cyc;
    bit            hold;
    bit            advance;
    logic [EW-1:0] held;
    logic [EW-1:0] exp;
    sent = 0;
    got  = 0;
    cyc  = 0;
    hold = 1'b0;
    held = '0;
    drive_random(TW'(sent));
    while (got < n_beats && cyc < 2000) begin
      advance   = 1'b0;
      in_valid  = (sent < n_beats);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, int'(in_amt), in_mode, in_dir, in_tag) & CMP_MASK);
        sent++;
        advance = 1'b1;
      end
      if (hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || (act_vec() & CMP_MASK) !== held) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%b vec=%h want valid=1 vec=%h", out_valid, act_vec() & CMP_MASK, held);
        end
      end
      hold = 1'b0;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stream_extra: got vec=%h want no output", act_vec());
        end else begin
          exp = exp_q.pop_front();
          if ((act_vec() & CMP_MASK) !== exp) begin
            n_err++;
            $display("FAIL stream_result[%0d]: got vec=%h want %h", got, act_vec() & CMP_MASK, exp);
          end
        end
        got++;
      end else if (out_valid) begin
        hold = 1'b1;
        held = act_vec() & CMP_MASK;
      end
      @(posedge clk);
      #1 cyc++;
      if (advance) drive_random(TW'(sent));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got != n_beats || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_count: got %0d results (%0d pending) want %0d", got, exp_q.size(), n_beats);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_in_flight();
    bit seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(8'hA5 + W'(i), 3'd1, 2'b00, 1'b0, TW'(i + 1));
      in_valid = 1'b1;
      if (i == 2) rst_n = 1'b0;
      @(negedge clk);
      if (i == 2) begin
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL flight_during_reset: got in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
        end
      end
      @(posedge clk);
      #1;
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_data !== '0 || out_ovf !== 1'b0 || out_tag !== '0) begin
      n_err++;
      $display("FAIL flight_outputs_zero: got data=%h ovf=%b tag=%h want 0/0/0", out_data, out_ovf, out_tag);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flight_in_ready: got %b want 1", in_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL flight_no_output: got out_valid=1 want 0 for discarded beats");
    end
    @(posedge clk);
    #1;
  endtask

`ifdef BARREL_SHIFTER_STICKY_EN
  task automatic test_sticky();
    logic [W-1:0] s_d [2];
    logic         s_s [2];
    int           lat;
    s_d[0] = 8'h05;
    s_s[0] = 1'b1;
    s_d[1] = 8'h04;
    s_s[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_beat(s_d[i], 3'd2, 2'b00, 1'b1, TW'(i));
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
        @(negedge clk);
        if (out_valid) break;
        @(posedge clk);
        #1 lat++;
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h01 || out_sticky !== s_s[i]) begin
        n_err++;
        $display("FAIL sticky[%0d]: got valid=%b data=%h sticky=%b want 1/01/%b",
                 i, out_valid, out_data, out_sticky, s_s[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back(16, 1'b0);
    test_back_to_back(40, 1'b1);
    test_reset_in_flight();
`ifdef BARREL_SHIFTER_STICKY_EN
    test_sticky();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter with valid/ready flow control on both sides. It supports logical, arithmetic and rotate shifts in either direction, flags signed overflow on arithmetic left shifts, and carries a sideband tag through the pipe. It sits between the operand-issue logic and the result-writeback stage of the datapath benchmarks. It replaces the combinational arithmetic shifter wherever timing requires one register per shift stage.

Parameters:
WIDTH, 32, data width; must be a power of two and at least 2.
TAG_W, 4, sideband tag width passed through unchanged; must be at least 1.
SH_W, $clog2(WIDTH), derived shift-amount width; not overridden.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  input beat valid.
in_ready  out  1  pipe can accept a beat this cycle.
in_data  in  WIDTH  operand (signed for arithmetic mode).
in_amt  in  SH_W  shift amount, 0..WIDTH-1.
in_mode  in  2  shift kind: 00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
in_dir  in  1  direction: 0 left, 1 right.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  WIDTH  shifted result.
out_ovf  out  1  arithmetic-left signed overflow.
out_tag  out  TAG_W  tag of this result.

Behaviour:
- Pipe structure: SH_W register stages. Stage k (k = 0..SH_W-1) shifts by 2^k when bit k of the carried amount is set, otherwise it passes the data through. Mode, dir, amt, tag and ovf ride along with the data.
- Latency is exactly SH_W cycles from input acceptance to out_valid when there are no stalls. Throughput is 1 beat per cycle.
- Transfer occurs on valid & ready on both sides.
- Stage k loads when it is empty or its contents move to stage k+1 (or out) in the same cycle. in_ready = stage 0 is empty or advancing. in_ready never depends on in_valid.
- Bubbles collapse: an empty stage loads even if downstream stages are stalled.
- Stalls: while out_valid & !out_ready, out_data, out_ovf and out_tag hold stable. No beat is lost or duplicated.
- Logical left/right: zero fill.
- Arithmetic right: fill with the sign bit of the current stage input.
- Arithmetic left: same data result as logical left.
- Rotate: bits shifted out re-enter at the opposite end.
- Amount 0: out_data = in_data in every mode; out_ovf = 0.
- Overflow (mode 01, dir 0 only): a stage shifting by s sets the accumulated ovf if its top s+1 bits are not all equal. Ovf is sticky through later stages. Net effect: out_ovf = 1 iff in_data * 2^amt is not representable in WIDTH signed bits. For all other mode/dir combinations out_ovf = 0.
- Reset (rst_n = 0 at a clock edge):
  - All stage valids clear; in-flight beats are discarded; no output appears for them.
  - out_valid = 0, out_data = 0, out_ovf = 0, out_tag = 0.
  - in_ready = 0 while rst_n is low, and 1 in the first cycle after release.

Optional Feature:
Macro BARREL_SHIFTER_STICKY_EN.
- Defined: adds output out_sticky (1 bit) = OR of every bit shifted off the low end during a right shift. Applies to logical and arithmetic modes only; it is 0 for rotates and left shifts. It is accumulated per stage, follows the same stall/reset rules as out_ovf, and resets to 0.
- Undefined: the port and its logic are absent.

Decomposition:
- Package shifter_pkg holds:
  - enum shift_mode_e {SHIFT_LOGICAL = 2'b00, SHIFT_ARITH = 2'b01, SHIFT_ROTATE = 2'b10};
  - localparam DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1;
  - a helper function computing the shift-amount width.
- One sub-module, barrel_shift_stage (parameters WIDTH, TAG_W, STAGE_IDX): a single registered stage with its valid/ready logic, instantiated SH_W times by a generate loop.

Test Plan:
- WIDTH=8, data 0x96, amt 3, arithmetic right -> out_data 0xF2, out_ovf 0, after exactly 3 cycles.
- Data 0x96, amt 3, rotate left -> 0xB4. Same data with rotate right -> 0xD2. Logical right -> 0x12.
- Data 0x30, amt 1, arithmetic left -> 0x60, ovf 0. Data 0x30, amt 2 -> 0xC0, ovf 1. Data 0xF0, amt 3 -> 0x80, ovf 0.
- Back-to-back stream of 16 beats with out_ready toggled 1,0,0,1,… -> all 16 results emerge in order with matching tags, outputs stable while stalled, no loss.
- Three beats in flight, rst_n pulsed low for 1 cycle -> out_valid never asserts for those beats; all outputs 0; in_ready = 1 on the cycle after release.
- With BARREL_SHIFTER_STICKY_EN: data 0x05, amt 2, logical right -> out_data 0x01, out_sticky 1. Data 0x04, amt 2 -> out_data 0x01, out_sticky 0.
